congestion_reporter: RTL

- Per-router source of the CONGw-bit congestion field.
- One instance per router; its `congestion_out` slices are concatenated, router i at bits [(i+1)*CONGw-1 : i*CONGw], into the congestion_in_all bus consumed by the port-preselection agent.
- Tracks downstream credit usage on the router's four directional output ports and averages occupancy over a fixed window.
- Quantizes the average to a CONGw-bit level and reports it once per window with a valid strobe.

---
 rtl/congestion_reporter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/congestion_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : congestion_reporter
//  Description : Per-router congestion field source. Tracks downstream
//                credits on every output port, sums the credits in use on
//                the directional ports (1..P-1) over a fixed window, and
//                quantizes the window total to a CONGW-bit level. The level
//                is reported once per window together with a valid strobe.
//
//  Ports       : clk            - clock
//                reset          - synchronous, active-low reset
//                flit_sent[P]   - one downstream credit consumed on port p
//                credit_in[P]   - one downstream credit returned on port p
//                congestion_out - level, 0 = idle .. LEVELS-1 = saturated
//                cong_valid     - one-cycle pulse when a new level is loaded
//                credit_err     - sticky credit over/underflow flag
//
//  Options     : CONG_REPORTER_DEBUG_EN - when defined, credit_err is a
//                sticky error register and each credit over/underflow is
//                reported by a simulation message. When undefined,
//                credit_err is tied to 0.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module congestion_reporter #(
    parameter int P                = 5,
    parameter int B                = 4,
    parameter int WINDOW           = 16,
    parameter int CONGESTION_INDEX = 2,
    localparam int CONGW = (CONGESTION_INDEX == 3 || CONGESTION_INDEX == 5 ||
                            CONGESTION_INDEX == 7 || CONGESTION_INDEX == 9 ||
                            CONGESTION_INDEX == 12) ? 3 :
                           (CONGESTION_INDEX == 10) ? 4 : 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [P-1:0]     flit_sent,
    input  logic [P-1:0]     credit_in,
    output logic [CONGW-1:0] congestion_out,
    output logic             cong_valid,
    output logic             credit_err
);

    localparam int LEVELS = 1 << CONGW;
    localparam int MAXACC = WINDOW * B * (P - 1);
    localparam int ACCW   = $clog2(MAXACC + 1);
    localparam int CRW    = $clog2(B + 1);
    localparam int WCW    = $clog2(WINDOW);

    logic [CRW-1:0]   cr_q [P];
    logic [CRW-1:0]   cr_d [P];
    logic [ACCW-1:0]  acc_q;
    logic [WCW-1:0]   wcnt_q;
    logic [CONGW-1:0] cong_q;
    logic             valid_q;

    logic [ACCW-1:0]  used;
    logic [ACCW-1:0]  sum;
    logic [CONGW-1:0] level;
    logic             win_end;

    // Credit counters saturate at 0 and B; a simultaneous send and return
    // leaves the count untouched.
    always_comb begin : p_credit
        for (int p = 0; p < P; p++) begin
            cr_d[p] = cr_q[p];
            if (flit_sent[p] && !credit_in[p] && (cr_q[p] != '0)) begin
                cr_d[p] = cr_q[p] - CRW'(1);
            end else if (credit_in[p] && !flit_sent[p] && (cr_q[p] != CRW'(B))) begin
                cr_d[p] = cr_q[p] + CRW'(1);
            end
        end
    end

    // Occupancy comes from the registered counters, so this cycle's
    // traffic is seen one cycle later. Port 0 (local) is excluded.
    always_comb begin : p_used
        int u;
        u = 0;
        for (int p = 1; p < P; p++) begin
            u = u + (B - int'(cr_q[p]));
        end
        used = ACCW'(u);
        sum  = acc_q + used;
    end

    // Level = number of thresholds T_k = k*MAXACC/LEVELS reached by sum.
    always_comb begin : p_quant
        int n;
        n = 0;
        for (int k = 1; k < LEVELS; k++) begin
            if (int'(sum) >= (k * MAXACC) / LEVELS) begin
                n = n + 1;
            end
        end
        level = CONGW'(n);
    end

    assign win_end = (wcnt_q == WCW'(WINDOW - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int p = 0; p < P; p++) begin
                cr_q[p] <= CRW'(B);
            end
            acc_q   <= '0;
            wcnt_q  <= '0;
            cong_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            for (int p = 0; p < P; p++) begin
                cr_q[p] <= cr_d[p];
            end
            // WINDOW is a power of two, so the counter wraps naturally.
            wcnt_q <= wcnt_q + WCW'(1);
            if (win_end) begin
                acc_q   <= '0;
                cong_q  <= level;
                valid_q <= 1'b1;
            end else begin
                acc_q   <= sum;
                valid_q <= 1'b0;
            end
        end
    end

    assign congestion_out = cong_q;
    assign cong_valid     = valid_q;

`ifdef CONG_REPORTER_DEBUG_EN
    logic [P-1:0] ovf;
    logic [P-1:0] unf;
    logic         err_q;

    always_comb begin : p_events
        for (int p = 0; p < P; p++) begin
            ovf[p] = credit_in[p] && !flit_sent[p] && (cr_q[p] == CRW'(B));
            unf[p] = flit_sent[p] && !credit_in[p] && (cr_q[p] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            if ((|ovf) || (|unf)) begin
                err_q <= 1'b1;
            end
            for (int p = 0; p < P; p++) begin
                if (ovf[p]) $display("%0t congestion_reporter: port %0d overflow", $time, p);
                if (unf[p]) $display("%0t congestion_reporter: port %0d underflow", $time, p);
            end
        end
    end

    assign credit_err = err_q;
`else
    assign credit_err = 1'b0;
`endif

endmodule
`default_nettype wire
